// File: rtl/priority_decoder_stream.sv
// Binary-to-one-hot decoder behind a small valid/ready FIFO. Decode happens at push; head is presented one cycle after a push into empty.
// Backpressure: in_ready is registered !full; out_* hold while out_valid && !out_ready.
module priority_decoder_stream #(
  parameter int N_OUT      = 8,
  parameter int CODE_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CODE_W-1:0]             in_code,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_OUT-1:0]              out_onehot,
  output logic [CODE_W-1:0]             out_code,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]     FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [CODE_W:0]   N_LIMIT  = (CODE_W + 1)'(N_OUT);
  localparam logic [N_OUT-1:0]  ONE_BIT  = N_OUT'(1);

  typedef struct packed {
    logic              err;
    logic [CODE_W-1:0] code;
    logic [N_OUT-1:0]  onehot;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        din;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push;
  logic          pop;

  assign push      = in_valid && in_ready;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;

  // Out-of-range codes are flagged rather than aliased onto a lower output.
  always_comb begin
    din      = '0;
    din.code = in_code;
    if ({1'b0, in_code} < N_LIMIT) begin
      din.onehot = ONE_BIT << in_code;
    end else begin
      din.err = 1'b1;
    end
  end

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (!push && pop) begin
      level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level    <= level_nxt;
      in_ready <= (level_nxt != FULL_LVL);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head       = out_valid ? mem[rd_ptr] : '0;
  assign out_onehot = head.onehot;
  assign out_code   = head.code;
  assign out_err    = head.err;

endmodule
